// File: rtl/adder_flags.sv
// Registered WIDTH-bit adder with carry-in producing sum plus C/V/Z status flags.
// Define ADDER_NEG_FLAG_EN to add a registered negative flag output N.
module adder_flags #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             C,
  output logic             V,
  output logic             Z,
`ifdef ADDER_NEG_FLAG_EN
  output logic             N,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] sumNext;
  logic             carryNext;
  logic             overflowNext;
  logic             zeroNext;

  // One bit wider than the operands so the carry-out falls out as the top bit.
  always_comb begin
    full         = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sumNext      = full[WIDTH-1:0];
    carryNext    = full[WIDTH];
    overflowNext = (a[WIDTH-1] == b[WIDTH-1]) && (sumNext[WIDTH-1] != a[WIDTH-1]);
    zeroNext     = (sumNext == '0);
  end

  // Result and flags only load on valid inputs, so garbage operands on idle cycles are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      C   <= 1'b0;
      V   <= 1'b0;
      Z   <= 1'b0;
    end else if (in_valid) begin
      sum <= sumNext;
      C   <= carryNext;
      V   <= overflowNext;
      Z   <= zeroNext;
    end
  end

`ifdef ADDER_NEG_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      N <= 1'b0;
    end else if (in_valid) begin
      N <= sumNext[WIDTH-1];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_adder_flags.sv
// Self-checking bench for adder_flags: arithmetic reference model, per-cycle compare,
// directed literal vectors and randomized operands. Honours ADDER_NEG_FLAG_EN.
module tb_adder_flags;

  localparam int WIDTH = 8;
  localparam int MOD   = 2 ** WIDTH;
  localparam int HALF  = 2 ** (WIDTH - 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             C;
  logic             V;
  logic             Z;
  logic             out_valid;
`ifdef ADDER_NEG_FLAG_EN
  logic             N;
`endif

  int errors = 0;
  int checks = 0;
  bit compareOn = 1'b0;

  adder_flags #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .C         (C),
    .V         (V),
    .Z         (Z),
`ifdef ADDER_NEG_FLAG_EN
    .N         (N),
`endif
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state, derived from integer arithmetic and signed-range reasoning.
  int expSum = 0;
  int expC   = 0;
  int expV   = 0;
  int expZ   = 0;
  int expN   = 0;
  int expOv  = 0;

  function automatic int toSigned(input int u);
    return (u >= HALF) ? u - MOD : u;
  endfunction

  function automatic int modelSum(input int x, input int y, input int ci);
    return (x + y + ci) % MOD;
  endfunction

  function automatic int modelCarry(input int x, input int y, input int ci);
    return ((x + y + ci) >= MOD) ? 1 : 0;
  endfunction

  function automatic int modelOverflow(input int x, input int y, input int ci);
    int s;
    s = toSigned(x) + toSigned(y) + ci;
    return (s > HALF - 1 || s < -HALF) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expSum <= 0;
      expC   <= 0;
      expV   <= 0;
      expZ   <= 0;
      expN   <= 0;
      expOv  <= 0;
    end else begin
      expOv <= int'(in_valid);
      if (in_valid) begin
        expSum <= modelSum(int'(a), int'(b), int'(cin));
        expC   <= modelCarry(int'(a), int'(b), int'(cin));
        expV   <= modelOverflow(int'(a), int'(b), int'(cin));
        expZ   <= (modelSum(int'(a), int'(b), int'(cin)) == 0) ? 1 : 0;
        expN   <= (modelSum(int'(a), int'(b), int'(cin)) >= HALF) ? 1 : 0;
      end
    end
  end

  task automatic checkOutput(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Every falling edge, the DUT must agree with the model on all outputs.
  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("cmp.sum", int'(sum), expSum);
      checkOutput("cmp.C", int'(C), expC);
      checkOutput("cmp.V", int'(V), expV);
      checkOutput("cmp.Z", int'(Z), expZ);
      checkOutput("cmp.out_valid", int'(out_valid), expOv);
`ifdef ADDER_NEG_FLAG_EN
      checkOutput("cmp.N", int'(N), expN);
`endif
    end
  end

  task automatic applyStimulus(input int x, input int y, input int ci, input bit vld);
    @(negedge clk);
    #1;
    in_valid = vld;
    a        = WIDTH'(x);
    b        = WIDTH'(y);
    cin      = ci[0];
  endtask

  task automatic checkLiteral(input string tag, input int s, input int c, input int v,
                              input int z, input int ov, input int n);
    @(posedge clk);
    #1;
    checkOutput({tag, ".sum"}, int'(sum), s);
    checkOutput({tag, ".C"}, int'(C), c);
    checkOutput({tag, ".V"}, int'(V), v);
    checkOutput({tag, ".Z"}, int'(Z), z);
    checkOutput({tag, ".out_valid"}, int'(out_valid), ov);
`ifdef ADDER_NEG_FLAG_EN
    checkOutput({tag, ".N"}, int'(N), n);
`else
    if (n < 0) $display("[TB] unexpected negative flag literal");
`endif
  endtask

  task automatic checkResetNow(input string tag);
    checkOutput({tag, ".sum"}, int'(sum), 0);
    checkOutput({tag, ".C"}, int'(C), 0);
    checkOutput({tag, ".V"}, int'(V), 0);
    checkOutput({tag, ".Z"}, int'(Z), 0);
    checkOutput({tag, ".out_valid"}, int'(out_valid), 0);
`ifdef ADDER_NEG_FLAG_EN
    checkOutput({tag, ".N"}, int'(N), 0);
`endif
  endtask

  function automatic int pickOperand();
    int r;
    r = int'($urandom_range(0, 9));
    case (r)
      0:       return 0;
      1:       return MOD - 1;
      2:       return HALF;
      3:       return HALF - 1;
      default: return int'($urandom_range(0, MOD - 1));
    endcase
  endfunction

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkResetNow("rst.initial");
    compareOn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(200, 100, 1, 1'b1);
    checkLiteral("v200_100", 45, 1, 0, 0, 1, 0);
    applyStimulus(50, 23, 0, 1'b1);
    checkLiteral("v50_23", 73, 0, 0, 0, 1, 0);
    applyStimulus('hD9, 'h83, 0, 1'b1);
    checkLiteral("vD9_83", 'h5C, 1, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1'b1);
    checkLiteral("vzero", 0, 0, 0, 1, 1, 0);
    applyStimulus('h80, 'h80, 0, 1'b1);
    checkLiteral("v80_80", 0, 1, 1, 1, 1, 0);
    applyStimulus(127, 1, 0, 1'b1);
    checkLiteral("v127_1", 128, 0, 1, 0, 1, 1);
    applyStimulus(5, 9, 1, 1'b0);
    checkLiteral("hold", 128, 0, 1, 0, 0, 1);
    applyStimulus('hFF, 'hFF, 1, 1'b1);
    checkLiteral("wrap", 'hFF, 1, 0, 0, 1, 1);

    // Idle cycle with unknown operands must leave outputs untouched.
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    cin      = 1'bx;
    checkLiteral("xidle", 'hFF, 1, 0, 0, 0, 1);

    // Mid-cycle reset clears outputs without a clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetNow("rst.async");
    applyStimulus(3, 4, 0, 1'b1);
    rst_n = 1'b1;
    checkLiteral("postrst", 7, 0, 0, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(pickOperand(), pickOperand(), int'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) < 7));
      if (i == 200) begin
        #2;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
      end
    end

    applyStimulus(0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    compareOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
